// File: rtl/sram_port0_ctrl.sv
// RW-port (port 0) front end for the 32x256 byte-masked SRAM macro: registered macro drive,
// two-stage read capture and a credit-checked response FIFO. Define SRAM_CLEAR_EN to zero the array after reset.
module sram_port0_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int NUM_WMASKS = 4,
   parameter int RSP_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [NUM_WMASKS-1:0] req_wmask,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0,
   output logic                  busy
);
   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int OCC_W = CNT_W + 1;

   typedef enum logic [1:0] {ST_INIT = 2'd0, ST_CLEAR = 2'd1, ST_RUN = 2'd2} state_e;

   state_e                state_q, state_d;
   logic                  csb_q, csb_d;
   logic                  web_q, web_d;
   logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] din_q, din_d;
   logic                  rd_s1_q, rd_s1_d;
   logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_d [RSP_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
`ifdef SRAM_CLEAR_EN
   logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
`endif

   logic             rd_s0;
   logic             accept;
   logic             push;
   logic             pop;
   logic [OCC_W-1:0] occupancy;

   // A read occupies a credit from acceptance until it is popped, so in-flight reads count too.
   assign rd_s0     = ~csb_q & web_q;
   assign occupancy = OCC_W'(count_q) + OCC_W'(rd_s0) + OCC_W'(rd_s1_q);
   assign req_ready = (state_q == ST_RUN) && (occupancy < OCC_W'(RSP_DEPTH));
   assign accept    = req_valid & req_ready;
   assign push      = rd_s1_q;
   assign rsp_valid = (count_q != '0);
   assign pop       = rsp_valid & rsp_ready;
   assign rsp_rdata = fifo_q[rd_ptr_q];

   assign sram_csb0   = csb_q;
   assign sram_web0   = web_q;
   assign sram_wmask0 = wmask_q;
   assign sram_addr0  = addr_q;
   assign sram_din0   = din_q;

`ifdef SRAM_CLEAR_EN
   assign busy = (state_q != ST_RUN);
`else
   assign busy = 1'b0;
`endif

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      csb_d   = 1'b1;
      web_d   = 1'b1;
      wmask_d = wmask_q;
      addr_d  = addr_q;
      din_d   = din_q;
`ifdef SRAM_CLEAR_EN
      clr_addr_d = clr_addr_q;
`endif
      unique case (state_q)
         ST_INIT: begin
`ifdef SRAM_CLEAR_EN
            state_d = ST_CLEAR;
`else
            state_d = ST_RUN;
`endif
         end
`ifdef SRAM_CLEAR_EN
         ST_CLEAR: begin
            csb_d      = 1'b0;
            web_d      = 1'b0;
            wmask_d    = '1;
            addr_d     = clr_addr_q;
            din_d      = '0;
            clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
            if (clr_addr_q == '1) state_d = ST_RUN;
         end
`endif
         ST_RUN: begin
            if (accept) begin
               csb_d   = 1'b0;
               web_d   = ~req_we;
               wmask_d = req_wmask;
               addr_d  = req_addr;
               din_d   = req_wdata;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // The macro samples a read one edge after the drive registers load; its data is captured one edge later.
   always_comb begin
      rd_s1_d  = rd_s0;
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         fifo_d[wr_ptr_q] = sram_dout0;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignment so all flops update together.
         state_q  <= ST_INIT;
         csb_q    <= 1'b1;
         web_q    <= 1'b1;
         wmask_q  <= '0;
         addr_q   <= '0;
         din_q    <= '0;
         rd_s1_q  <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         // NOTE: the FIFO storage is reset because its head drives rsp_rdata, which must read 0 out of reset.
         for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
`ifdef SRAM_CLEAR_EN
         clr_addr_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         csb_q    <= csb_d;
         web_q    <= web_d;
         wmask_q  <= wmask_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         rd_s1_q  <= rd_s1_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         fifo_q   <= fifo_d;
`ifdef SRAM_CLEAR_EN
         clr_addr_q <= clr_addr_d;
`endif
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && (count_q == CNT_W'(RSP_DEPTH))));

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// Bench for sram_port0_ctrl: behavioural macro, transaction-level reference model checked every cycle,
// plus directed vectors with literal expectations. Honours SRAM_CLEAR_EN when defined.
module tb_sram_port0_ctrl;
   localparam int DW = 32;
   localparam int AW = 8;
   localparam int MW = 4;
   localparam int DEPTH = 4;
`ifdef SRAM_CLEAR_EN
   localparam int RUN_CYC = 257;
`else
   localparam int RUN_CYC = 1;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready, req_we;
   logic [MW-1:0] req_wmask;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          sram_csb0, sram_web0;
   logic [MW-1:0] sram_wmask0;
   logic [AW-1:0] sram_addr0;
   logic [DW-1:0] sram_din0, sram_dout0;
   logic          busy;

   sram_port0_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(MW), .RSP_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_wmask(req_wmask),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
      .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural macro: samples controls on posedge, acts on the following negedge.
   logic [DW-1:0] mac_mem [256];
   logic          m_csb, m_web;
   logic [MW-1:0] m_wmask;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_din;

   initial begin
      for (int i = 0; i < 256; i++) mac_mem[i] = 32'hC0DE_0000 | i;
      m_csb = 1'b1;
      m_web = 1'b1;
      sram_dout0 = '0;
   end

   always @(posedge clk) begin
      m_csb   <= sram_csb0;
      m_web   <= sram_web0;
      m_wmask <= sram_wmask0;
      m_addr  <= sram_addr0;
      m_din   <= sram_din0;
   end

   always @(negedge clk) begin
      if (!m_csb) begin
         if (!m_web) begin
            for (int b = 0; b < MW; b++)
               if (m_wmask[b]) mac_mem[m_addr][8*b +: 8] = m_din[8*b +: 8];
         end else begin
            sram_dout0 = mac_mem[m_addr];
         end
      end
   end

   // Reference model: array updated at acceptance, reads queued with the cycle their data must show.
   typedef struct {
      logic [DW-1:0] data;
      int            rdy;
   } exp_t;

   logic [DW-1:0] ref_mem [256];
   exp_t          exp_q [$];
   int            cyc;
   int            n_rsp = 0;
   logic          last_acc, last_we;
   logic [AW-1:0] last_addr;

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE_0000 | i;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         last_acc = 1'b0;
         last_we  = 1'b0;
`ifdef SRAM_CLEAR_EN
         for (int i = 0; i < 256; i++) ref_mem[i] = '0;
`endif
      end else begin : compare
         logic exp_valid;
         exp_valid = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
         check("rsp_valid", rsp_valid, exp_valid);
         if (exp_valid) check("rsp_rdata", rsp_rdata, exp_q[0].data);
         check("req_ready", req_ready, (cyc >= RUN_CYC) && (exp_q.size() < DEPTH));
         if (cyc > RUN_CYC) begin
            check("sram_csb0", sram_csb0, !last_acc);
            check("sram_web0", sram_web0, !(last_acc && last_we));
            if (last_acc) check("sram_addr0", sram_addr0, last_addr);
         end
         last_acc  = req_valid && req_ready;
         last_we   = req_we;
         last_addr = req_addr;
         if (last_acc) begin
            if (req_we) begin
               for (int b = 0; b < MW; b++)
                  if (req_wmask[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
            end else begin
               exp_q.push_back('{data: ref_mem[req_addr], rdy: cyc + 3});
            end
         end
         if (rsp_valid && rsp_ready) begin
            n_rsp++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
      end
   end

   // Drive a request from posedge+1 and hold it until accepted (bounded wait).
   task automatic send(input logic we, input logic [MW-1:0] m, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int waited);
      req_valid = 1'b1;
      req_we    = we;
      req_wmask = m;
      req_addr  = a;
      req_wdata = d;
      waited    = 0;
      @(negedge clk);
      while (!req_ready && waited < 400) begin
         waited++;
         @(negedge clk);
      end
      if (!req_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL send_timeout: request to addr 0x%0h never accepted", a);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin : stim
      int w;
      int base;
      int acc;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_wmask = '0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;
      step(3);
      check("rst_csb0", sram_csb0, 1'b1);
      check("rst_web0", sram_web0, 1'b1);
      check("rst_wmask0", sram_wmask0, '0);
      check("rst_addr0", sram_addr0, '0);
      check("rst_din0", sram_din0, '0);
      check("rst_req_ready", req_ready, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_rdata", rsp_rdata, '0);
`ifdef SRAM_CLEAR_EN
      check("rst_busy", busy, 1'b1);
`else
      check("rst_busy", busy, 1'b0);
`endif
      rst_n = 1'b1;

`ifdef SRAM_CLEAR_EN
      while (cyc < 256) @(negedge clk);
      check("clear_busy_last", busy, 1'b1);
      check("clear_ready_last", req_ready, 1'b0);
      @(negedge clk);
      check("clear_busy_done", busy, 1'b0);
      check("clear_ready_done", req_ready, 1'b1);
      @(posedge clk);
      #1;
      send(1'b0, '0, 8'd0, '0, w);
      send(1'b0, '0, 8'd255, '0, w);
      send(1'b0, '0, 8'd128, '0, w);
      step(2);
      check("clear_rd128_valid", rsp_valid, 1'b1);
      check("clear_rd128_data", rsp_rdata, 32'h0);
      step(4);
`else
      @(negedge clk);
      check("run_busy", busy, 1'b0);
      @(posedge clk);
      #1;
`endif

      // Full write then read-after-write with exact 2-cycle latency.
      send(1'b1, 4'hF, 8'h10, 32'hDEAD_BEEF, w);
      send(1'b0, 4'h0, 8'h10, 32'h0, w);
      check("raw_valid_n0", rsp_valid, 1'b0);
      step(1);
      check("raw_valid_n1", rsp_valid, 1'b0);
      step(1);
      check("raw_valid_n2", rsp_valid, 1'b1);
      check("raw_data", rsp_rdata, 32'hDEAD_BEEF);
      step(2);

      // Partial byte-lane write and a zero-mask write.
      send(1'b1, 4'hF, 8'h20, 32'h1122_3344, w);
      send(1'b1, 4'b0101, 8'h20, 32'hAABB_CCDD, w);
      send(1'b1, 4'b0000, 8'h20, 32'hFFFF_FFFF, w);
      send(1'b0, 4'h0, 8'h20, 32'h0, w);
      step(2);
      check("mask_data", rsp_rdata, 32'h11BB_33DD);
      step(2);

      // Streaming reads at full throughput.
      base = n_rsp;
      for (int i = 0; i < 8; i++) begin
         send(1'b0, 4'h0, AW'(i), 32'h0, w);
         check("stream_no_stall", w, 0);
      end
      step(4);
      check("stream_rsp_count", n_rsp - base, 8);

      // Backpressure: credit limit stops acceptance at the FIFO depth.
      rsp_ready = 1'b0;
      base      = n_rsp;
      acc       = 0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 8'h08;
      repeat (10) begin
         @(negedge clk);
         if (req_ready) acc++;
         @(posedge clk);
         #1;
         req_addr = AW'(8 + acc);
      end
      req_valid = 1'b0;
      check("bp_accepted", acc, 4);
      check("bp_ready_low", req_ready, 1'b0);
      check("bp_no_pop", n_rsp - base, 0);
      rsp_ready = 1'b1;
      step(6);
      check("bp_drained", n_rsp - base, 4);

      // Reset with two reads in flight.
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 8'h30;
      step(1);
      req_addr  = 8'h31;
      step(1);
      req_valid = 1'b0;
      check("inflight_csb0", sram_csb0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_csb0", sram_csb0, 1'b1);
      check("async_rsp_valid", rsp_valid, 1'b0);
      check("async_req_ready", req_ready, 1'b0);
      base = n_rsp;
      step(2);
      rst_n = 1'b1;
      step(8);
      check("no_stale_rsp", n_rsp - base, 0);
      send(1'b0, 4'h0, 8'h31, 32'h0, w);
      step(3);
      check("post_reset_rsp", n_rsp - base, 1);
      check("model_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end
endmodule
